// File: rtl/sm_result_decoder_if.sv
// Result channel between the sign-magnitude adder, the decoder and its consumer.
// The slave side is the decoder; the master side drives results in and takes values out.
interface sm_result_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [8:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_value;
  logic       out_at_max;
  logic       out_at_min;
  logic       out_err;

  modport slave (
    input  in_valid, in_sign, in_result, out_ready,
    output in_ready, out_valid, out_value, out_at_max, out_at_min, out_err
  );

  modport master (
    output in_valid, in_sign, in_result, out_ready,
    input  in_ready, out_valid, out_value, out_at_max, out_at_min, out_err
  );
endinterface

// File: rtl/sm_result_decoder.sv
// Decodes {sign, magnitude} adder results into 9-bit two's complement and buffers them in a FIFO.
// Defining SM_DEC_STATS_EN builds the saturating err/limit statistics counters.
module sm_result_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sm_result_decoder_if.slave bus,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   limit_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  // Entry layout: {err, at_min, at_max, value[8:0]}
  logic [11:0]   mem_reg [DEPTH];
  logic [11:0]   head;

  logic       push, pop;
  logic [8:0] dec_value;
  logic       dec_err, dec_at_max, dec_at_min;

  assign bus.in_ready  = (count_reg < DEPTH_C);
  assign bus.out_valid = (count_reg != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Illegal encodings are clamped to the nearest limit so downstream never sees a wrapped value.
  always_comb begin
    dec_value = '0;
    dec_err   = 1'b0;
    if (!bus.in_sign) begin
      if (bus.in_result[8]) begin
        dec_value = 9'h0FF;
        dec_err   = 1'b1;
      end else begin
        dec_value = {1'b0, bus.in_result[7:0]};
      end
    end else if (bus.in_result == 9'd0) begin
      dec_value = '0;
      dec_err   = 1'b1;
    end else if (bus.in_result > 9'h100) begin
      dec_value = 9'h100;
      dec_err   = 1'b1;
    end else begin
      dec_value = ~bus.in_result + 9'd1;
    end
  end

  assign dec_at_max = (dec_value == 9'h0FF);
  assign dec_at_min = (dec_value == 9'h100);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem_reg[wr_ptr_reg] <= {dec_err, dec_at_min, dec_at_max, dec_value};
  end

  assign head           = mem_reg[rd_ptr_reg];
  assign bus.out_value  = bus.out_valid ? head[8:0] : 9'd0;
  assign bus.out_at_max = bus.out_valid & head[9];
  assign bus.out_at_min = bus.out_valid & head[10];
  assign bus.out_err    = bus.out_valid & head[11];

`ifdef SM_DEC_STATS_EN
  logic [CNT_W-1:0] err_count_reg, limit_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      err_count_reg   <= '0;
      limit_count_reg <= '0;
    end else if (push) begin
      if (dec_err && (err_count_reg != '1))
        err_count_reg <= err_count_reg + CNT_W'(1);
      if ((dec_at_max || dec_at_min) && (limit_count_reg != '1))
        limit_count_reg <= limit_count_reg + CNT_W'(1);
    end
  end

  assign err_count   = err_count_reg;
  assign limit_count = limit_count_reg;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign err_count   = '0;
  assign limit_count = '0;
`endif

endmodule

// File: tb/tb_sm_result_decoder.sv
// Directed bench for sm_result_decoder: decode table, flags, FIFO flow control, counters, reset.
module tb_sm_result_decoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef SM_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic stats_clr;
  logic [CNT_W-1:0] err_count, limit_count;
  int total, bad;

  sm_result_decoder_if bus();

  sm_result_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stats_clr(stats_clr),
    .err_count(err_count), .limit_count(limit_count)
  );

  // {out_valid, out_err, out_at_min, out_at_max, out_value}
  wire [12:0] head = {bus.out_valid, bus.out_err, bus.out_at_min, bus.out_at_max, bus.out_value};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [CNT_W-1:0] ecnt(input int n);
    return STATS ? CNT_W'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_one(input logic s, input logic [8:0] r);
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_result = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    total++;
    if (head !== 13'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_outputs: got head=%h ready=%b expected head=0000 ready=1", head, bus.in_ready);
    end
    total++;
    if (err_count !== '0 || limit_count !== '0) begin
      bad++; $display("FAIL reset_counters: got err=%0d lim=%0d expected 0 0", err_count, limit_count);
    end
    $display("reset: head=%h in_ready=%b", head, bus.in_ready);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_result = 9'd100;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (head !== {4'b1000, 9'd100}) begin
      bad++; $display("FAIL basic_head: got %h expected %h", head, {4'b1000, 9'd100});
    end
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_empty: got out_valid=%b expected 0", bus.out_valid);
    end
    $display("basic: push {0,100} -> value 100, drained");
  endtask

  task automatic test_limits();
    push_one(1'b1, 9'h100);
    push_one(1'b0, 9'h0FF);
    total++;
    if (head !== {4'b1010, 9'h100}) begin
      bad++; $display("FAIL limits_min: got %h expected %h", head, {4'b1010, 9'h100});
    end
    pop_one();
    total++;
    if (head !== {4'b1001, 9'h0FF}) begin
      bad++; $display("FAIL limits_max: got %h expected %h", head, {4'b1001, 9'h0FF});
    end
    pop_one();
    total++;
    if (limit_count !== ecnt(2) || err_count !== ecnt(0)) begin
      bad++; $display("FAIL limits_count: got lim=%0d err=%0d expected %0d %0d", limit_count, err_count, ecnt(2), ecnt(0));
    end
    $display("limits: -256 at_min, +255 at_max, limit_count=%0d", limit_count);
  endtask

  task automatic test_illegal();
    logic [9:0]  vin [3];
    logic [12:0] vexp [3];
    vin  = '{10'h200, 10'h1A0, 10'h301};
    vexp = '{{4'b1100, 9'h000}, {4'b1101, 9'h0FF}, {4'b1110, 9'h100}};
    for (int i = 0; i < 3; i++) push_one(vin[i][9], vin[i][8:0]);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (head !== vexp[i]) begin
        bad++; $display("FAIL illegal[%0d]: got %h expected %h", i, head, vexp[i]);
      end
      $display("illegal[%0d]: in=%h head=%h", i, vin[i], head);
      pop_one();
    end
    total++;
    if (err_count !== ecnt(3) || limit_count !== ecnt(4)) begin
      bad++; $display("FAIL illegal_count: got err=%0d lim=%0d expected %0d %0d", err_count, limit_count, ecnt(3), ecnt(4));
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL full_ready[%0d]: got %b expected 1", i, bus.in_ready);
      end
      push_one(1'b0, 9'(10 + i));
    end
    // Offer the first extra value while full; it must not be taken.
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_result = 9'(10 + DEPTH);
    tick(); tick();
    total++;
    if (bus.in_ready !== 1'b0 || head !== {4'b1000, 9'd10}) begin
      bad++; $display("FAIL full_stall: got ready=%b head=%h expected ready=0 head=%h", bus.in_ready, head, {4'b1000, 9'd10});
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (head !== {4'b1000, 9'(10 + i)}) begin
        bad++; $display("FAIL full_drain[%0d]: got %h expected %h", i, head, {4'b1000, 9'(10 + i)});
      end
      pop_one();
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL full_empty: got valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    for (int i = DEPTH; i < DEPTH + 2; i++) push_one(1'b0, 9'(10 + i));
    for (int i = DEPTH; i < DEPTH + 2; i++) begin
      total++;
      if (head !== {4'b1000, 9'(10 + i)}) begin
        bad++; $display("FAIL full_extra[%0d]: got %h expected %h", i, head, {4'b1000, 9'(10 + i)});
      end
      pop_one();
    end
    $display("full: %0d accepted, stalled, drained in order, extras delivered", DEPTH);
  endtask

  task automatic test_back_to_back();
    push_one(1'b0, 9'd50);
    push_one(1'b0, 9'd51);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_sign = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.in_result = 9'(52 + k);
      total++;
      if (head !== {4'b1000, 9'(50 + k)} || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b[%0d]: got head=%h ready=%b expected head=%h ready=1", k, head, bus.in_ready, {4'b1000, 9'(50 + k)});
      end
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int k = 70; k < 72; k++) begin
      total++;
      if (head !== {4'b1000, 9'(k)}) begin
        bad++; $display("FAIL b2b_tail[%0d]: got %h expected %h", k, head, {4'b1000, 9'(k)});
      end
      pop_one();
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_empty: got out_valid=%b expected 0", bus.out_valid);
    end
    $display("back_to_back: 20 cycles push+pop, occupancy held at 2");
  endtask

  task automatic test_stats_clr();
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_result = 9'h1A0; stats_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0; stats_clr = 1'b0;
    total++;
    if (err_count !== '0 || limit_count !== '0 || head !== {4'b1101, 9'h0FF}) begin
      bad++; $display("FAIL clr_priority: got err=%0d lim=%0d head=%h expected 0 0 %h", err_count, limit_count, head, {4'b1101, 9'h0FF});
    end
    pop_one();
    push_one(1'b1, 9'd0);
    pop_one();
    total++;
    if (err_count !== ecnt(1) || limit_count !== ecnt(0)) begin
      bad++; $display("FAIL clr_recount: got err=%0d lim=%0d expected %0d %0d", err_count, limit_count, ecnt(1), ecnt(0));
    end
    $display("stats_clr: err=%0d lim=%0d", err_count, limit_count);
  endtask

  task automatic test_reset_full();
    for (int i = 0; i < DEPTH; i++) push_one(1'b0, 9'h1A0);
    total++;
    if (bus.in_ready !== 1'b0 || err_count !== ecnt(5) || limit_count !== ecnt(4)) begin
      bad++; $display("FAIL rstfull_pre: got ready=%b err=%0d lim=%0d expected 0 %0d %0d", bus.in_ready, err_count, limit_count, ecnt(5), ecnt(4));
    end
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.in_sign = 1'b0; bus.in_result = 9'd7;
    tick();
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++;
    if (head !== 13'd0 || bus.in_ready !== 1'b1 || err_count !== '0 || limit_count !== '0) begin
      bad++; $display("FAIL rstfull_post: got head=%h ready=%b err=%0d lim=%0d expected 0000 1 0 0", head, bus.in_ready, err_count, limit_count);
    end
    $display("reset_full: head=%h in_ready=%b", head, bus.in_ready);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stats_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_result = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_limits();
    test_illegal();
    test_full();
    test_back_to_back();
    test_stats_clr();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm_result_decoder.md
Name: sm_result_decoder

Overview:
- Receive side of the sign-magnitude result interface produced by the signed-magnitude saturating adder: {sign, result[8:0]}.
- Accepts results with a valid/ready handshake and converts them back to 9-bit two's complement.
- Flags limit values (+255, -256) and illegal encodings.
- Buffers results in a small FIFO so a stalled consumer does not lose adder outputs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  decoder can accept a result.
- in_sign  input  1  sign bit; 1 means negative.
- in_result  input  9  magnitude.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_value  output  9  signed two's-complement value, range -256..255.
- out_at_max  output  1  head value equals +255.
- out_at_min  output  1  head value equals -256.
- out_err  output  1  head came from an illegal encoding.
- stats_clr  input  1  synchronous clear of the counters.
- err_count  output  CNT_W  number of illegal encodings accepted.
- limit_count  output  CNT_W  number of limit values accepted.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - FIFO pointers and count go to 0.
  - out_valid=0, in_ready=1.
  - out_value, out_at_max, out_at_min and out_err read 0.
  - Both counters go to 0.
- Accept (push): in_valid && in_ready at an edge. in_ready = (count < DEPTH). No combinational path from out_ready to in_ready.
- Pop: out_valid && out_ready at an edge. out_valid = (count != 0). Head fields come straight from registered FIFO storage.
- Latency: a result accepted at edge N is visible on out_* from edge N onward, i.e. out_valid is high in cycle N+1. There is no empty-FIFO bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
  - When full, in_ready=0, so no push occurs even if a pop happens the same cycle.
  - When empty, no pop occurs.
- Pointers wrap modulo DEPTH.
- Decode is combinational on the input and stored with the entry:
  - sign=0, result[8]=0: value = result (0..255).
  - sign=0, result[8]=1 (magnitude > 255): illegal. value = +255, err=1.
  - sign=1, result in 1..256: value = -result. 256 maps to -256 (9'h100).
  - sign=1, result > 256: illegal. value = -256, err=1.
  - sign=1, result = 0 (negative zero): value = 0, err=1.
- Flags: at_max = (value==255); at_min = (value==-256). Both are evaluated after clamping.
- Counters:
  - Counted only on accepted pushes; limit_count counts pushes where at_max or at_min is set.
  - Saturate at all-ones and do not wrap.
  - stats_clr has priority over an increment in the same cycle; that push is not counted.
- Mid-operation reset: the FIFO content is discarded, and any in-flight handshake in that cycle is ignored.
- Input fields are don't-care when in_valid=0, and nothing is written to the FIFO.

Optional Feature:
- Macro: SM_DEC_STATS_EN.
- Defined: err_count and limit_count behave as specified above.
- Undefined: no counter registers are built. err_count and limit_count are driven constant 0, and stats_clr is ignored. Ports remain present.

Test Plan:
- Reset, then push {0, 9'd100} with out_ready=1 -> out_valid rises the next cycle with out_value=100, out_at_max=0, out_err=0; FIFO empty after pop.
- Push {1, 9'h100}, then {0, 9'h0FF} -> out_value=-256 with at_min=1, then 255 with at_max=1; limit_count=2.
- Push {1, 0}, {0, 9'h1A0}, {1, 9'h101} -> values 0, 255, -256, each with out_err=1; err_count=3.
- Hold out_ready=0 and push DEPTH+2 values -> in_ready drops after DEPTH accepts. Releasing out_ready drains exactly DEPTH values in order, and the 2 extra inputs are held until in_ready returns.
- With the FIFO half full, assert in_valid and out_ready together for 20 cycles -> count stays constant, order is preserved, pointers wrap cleanly.
- Assert stats_clr in the same cycle as an illegal push -> err_count=0 afterwards.
- Drive rst_n=0 with the FIFO full -> next cycle out_valid=0, in_ready=1, counters=0.
